// File: rtl/dm_cache_responder.sv
// dm_cache_responder
//   Direct-mapped, write-back, write-allocate data cache.
//   - Word hits are served with no added latency.
//   - On a miss, the cache raises miss and stalls the requester.
//   - It then writes back the dirty victim line (if any) and refills the line
//     word-serially over a req/gnt main-memory port.
//
// Ports
//   clk, rst_n             clock (posedge), asynchronous active-low reset
//   addr                   byte address: [LINE+1:2] word, [SET+LINE+1:LINE+2] set, tag above
//   rd_req, wr_req         word read / write request (both high = write)
//   wr_data                write data
//   rd_data                read data, non-zero only when rd_req & hit in IDLE
//   miss                   request not yet served
//   mem_req, mem_we        main-memory transfer request; 1 = writeback, 0 = fill
//   mem_addr, mem_wdata    main-memory word address / writeback data
//   mem_rdata, mem_gnt     fill data / transfer completes this cycle
//
// Optional feature (macro CACHE_STATS_EN)
//   Adds the outputs hit_cnt[31:0] and miss_cnt[31:0].
module dm_cache_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 6,
    localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             addr,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    miss,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [MEM_ADDR_LEN-1:0] mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_gnt
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);

    localparam int SETS   = 2 ** SET_ADDR_LEN;
    localparam int WORDS  = 2 ** (SET_ADDR_LEN + LINE_ADDR_LEN);
    localparam int IDX_W  = SET_ADDR_LEN + LINE_ADDR_LEN;
    localparam int TAG_LO = SET_ADDR_LEN + LINE_ADDR_LEN + 2;
    localparam int TAG_HI = TAG_LO + TAG_ADDR_LEN - 1;
    localparam logic [LINE_ADDR_LEN-1:0] WORD0 = '0;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    logic [31:0]             data_arr [WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_arr  [SETS];
    logic [SETS-1:0]         valid;
    logic [SETS-1:0]         dirty;

    state_t                   state;
    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [SET_ADDR_LEN-1:0]  m_set;
    logic [TAG_ADDR_LEN-1:0]  m_tag;

    logic [LINE_ADDR_LEN-1:0] word_sel;
    logic [SET_ADDR_LEN-1:0]  set_sel;
    logic [TAG_ADDR_LEN-1:0]  tag_sel;
    logic                     req;
    logic                     hit;
    logic                     last;
    logic [LINE_ADDR_LEN-1:0] cnt_nxt;

    logic                     arr_we;
    logic [IDX_W-1:0]         arr_idx;
    logic [31:0]              arr_wdata;
    logic                     unused_bits;

    assign word_sel    = addr[LINE_ADDR_LEN+1:2];
    assign set_sel     = addr[TAG_LO-1:LINE_ADDR_LEN+2];
    assign tag_sel     = addr[TAG_HI:TAG_LO];
    assign unused_bits = ^{addr[1:0], addr[31:TAG_HI+1]};

    assign req     = rd_req | wr_req;
    assign hit     = valid[set_sel] && (tag_arr[set_sel] == tag_sel);
    assign miss    = (req && !hit) || (state != IDLE);
    assign rd_data = (rd_req && hit && state == IDLE) ? data_arr[{set_sel, word_sel}] : '0;
    assign last    = (cnt == '1);
    assign cnt_nxt = cnt + 1'b1;

    // Single write port into the data array: an IDLE write hit or a fill word.
    always_comb begin
        arr_we    = 1'b0;
        arr_idx   = {set_sel, word_sel};
        arr_wdata = wr_data;
        if (state == IDLE && wr_req && hit) begin
            arr_we = 1'b1;
        end else if (state == FILL && mem_gnt) begin
            arr_we    = 1'b1;
            arr_idx   = {m_set, cnt};
            arr_wdata = mem_rdata;
        end
    end

    // Data and tag storage carry no reset; only valid/dirty are cleared.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_arr[arr_idx] <= arr_wdata;
        end
        if (state == FILL && mem_gnt && last) begin
            tag_arr[m_set] <= m_tag;
        end
    end

    // Memory-port outputs are registered.
    // On every granted word the next address/data is preloaded,
    // so the outputs hold while mem_gnt is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            m_set     <= '0;
            m_tag     <= '0;
            valid     <= '0;
            dirty     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req && hit) begin
                        dirty[set_sel] <= 1'b1;
                    end else if (req && !hit) begin
                        m_set   <= set_sel;
                        m_tag   <= tag_sel;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        if (valid[set_sel] && dirty[set_sel]) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[set_sel], set_sel, WORD0};
                            mem_wdata <= data_arr[{set_sel, WORD0}];
                        end else begin
                            state     <= FILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {tag_sel, set_sel, WORD0};
                            mem_wdata <= '0;
                        end
                    end
                end
                WB: begin
                    if (mem_gnt) begin
                        cnt <= cnt_nxt;
                        if (last) begin
                            state     <= FILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {m_tag, m_set, WORD0};
                            mem_wdata <= '0;
                        end else begin
                            mem_addr  <= {mem_addr[MEM_ADDR_LEN-1:LINE_ADDR_LEN], cnt_nxt};
                            mem_wdata <= data_arr[{m_set, cnt_nxt}];
                        end
                    end
                end
                FILL: begin
                    if (mem_gnt) begin
                        cnt <= cnt_nxt;
                        if (last) begin
                            state        <= IDLE;
                            valid[m_set] <= 1'b1;
                            dirty[m_set] <= 1'b0;
                            mem_req      <= 1'b0;
                            mem_addr     <= '0;
                        end else begin
                            mem_addr <= {mem_addr[MEM_ADDR_LEN-1:LINE_ADDR_LEN], cnt_nxt};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // The cycle right after a fill is the one in which the missed request
    // finally hits.  It is part of that miss, so it is not counted as a hit.
    logic just_filled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            just_filled <= 1'b0;
        end else begin
            just_filled <= (state == FILL) && mem_gnt && last;
            if (state == IDLE && req && !hit) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (state == IDLE && req && hit && !just_filled) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
